interrupt_sequencer: RTL and testbench
======================================

// Module: interrupt_sequencer
// PURPOSE
// - Sequences the 6502 datapath through RESET, NMI, IRQ and BRK entry:
//   dummy/real stack pushes of PCH, PCL and P, vector fetch, then PC load.
// - Sits beside instruction_decode. It requests a bus takeover at instruction boundaries.
// - While seq_active=1 it owns address/rw/data_out; the decoder holds in S_IDLE.
// PARAMETERS
// - VEC_NMI  16'hFFFA  NMI vector low-byte address (high byte at +1)
// - VEC_RES  16'hFFFC  RESET vector low-byte address
// - VEC_IRQ  16'hFFFE  IRQ/BRK vector low-byte address
// PORTS
// - clk         in   1   system clock, all state on posedge
// - rst_n       in   1   asynchronous, active-low reset
// - clk_enable  in   1   state advances only on edges where clk_enable=1
// - irq         in   1   level interrupt request, active high
// - nmi         in   1   edge interrupt request, rising edge detected
// - i_flag      in   1   interrupt-disable flag from status register
// - brk_req     in   1   decoder has fetched BRK (valid with boundary)
// - boundary    in   1   decoder at opcode fetch; requests sampled only here
// - pc_in       in   16  current PC (pushed value)
// - sp_in       in   8   current stack pointer
// - status_in   in   7   {N,V,B,D,I,Z,C}; B is replaced when pushed
// - data_in     in   8   memory read data
// - seq_active  out  1   sequencer owns the bus; decoder must stall
// - address     out  16  bus address while seq_active
// - rw          out  1   1=read, 0=write
// - data_out    out  8   write data
// - sp_dec      out  1   pulse: decrement SP this enabled cycle
// - pc_load     out  1   pulse: load PC from pc_value
// - pc_value    out  16  {vec_hi, vec_lo} captured from memory
// - set_i       out  1   pulse with pc_load: set I flag
// BEHAVIOUR
// - Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
// - States: RST_HOLD, IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI, LOAD_PC.
//   Each state lasts exactly one clk_enable cycle.
// - rst_n low (async, even mid-sequence):
//   - state=RST_HOLD, kind=RESET, nmi_pending=0, vec regs=0.
//   - seq_active=1, rw=1, address=0, data_out=0, all pulses 0.
// - RST_HOLD -> PUSH_PCH on the first enabled edge after rst_n high.
// - IDLE: seq_active=0, rw=1, pulses 0. On an enabled edge with boundary=1, priority is:
//   - nmi_pending -> kind NMI.
//   - brk_req -> kind BRK.
//   - irq & !i_flag -> kind IRQ.
//   - otherwise stay IDLE. irq is ignored when boundary=0.
// - PUSH_PCH/PCL/P:
//   - address={8'h01, sp_in}; sp_dec=1.
//   - data_out: PCH=pc_in[15:8], PCL=pc_in[7:0], P={N,V,1,B',D,I,Z,C}. B'=1 for BRK only.
//   - rw=0, except kind RESET: rw=1 (dummy reads) with SP still decremented.
// - nmi edge detect: nmi_q registered every enabled edge; rising edge sets nmi_pending.
//   The edge is not lost if it arrives during a sequence.
// - Hijack: if kind is IRQ/BRK and nmi_pending=1 on the edge leaving PUSH_P, the vector
//   becomes VEC_NMI. A BRK keeps pushed B'=1.
// - Vector select is latched on entry to VEC_LO. nmi_pending clears on that edge when
//   NMI is selected; a new edge in the same cycle wins and re-sets it.
// - VEC_LO: address=vector, rw=1, data_in captured into vec_lo on exit.
// - VEC_HI: address=vector+1, rw=1, data_in captured into vec_hi on exit.
// - LOAD_PC: pc_load=1, set_i=1, pc_value={vec_hi,vec_lo}, seq_active=1; then IDLE.
// - Latency: accept edge to pc_load = 6 enabled cycles; seq_active falls the cycle after.
// - clk_enable=0: state, captures, edge detector frozen; outputs held steady.
// - Width: vector+1 computed 16-bit modulo (FFFF+1 wraps to 0000).
// - SP wrap is the SP register's responsibility (00 -> FF).
// TESTING
// - Reset: rst_n low 3 cycles, release, mem[FFFC]=34, mem[FFFD]=12 -> 3 reads at
//   01FF/01FE/01FD with no write, 3 sp_dec, then pc_load with pc_value=1234.
// - IRQ: i_flag=0, irq=1 at boundary, pc_in=C005, sp=FF, status N=1 -> writes
//   C0@01FF, 05@01FE, A0@01FD (B'=0), reads FFFE/FFFF, set_i.
// - Masked: i_flag=1, irq=1 for 20 cycles -> seq_active stays 0, no sp_dec.
// - BRK hijack: brk_req at boundary, nmi rises during PUSH_PCL -> P pushed with
//   bit4=1, vector reads FFFA/FFFB, nmi_pending=0 after.
// - Stall: drop clk_enable 4 cycles inside VEC_LO -> address stays FFFE, no advance.
//   Resume completes normally.
// - Abort: rst_n low during PUSH_P of an NMI -> immediately RST_HOLD, pending cleared.
//   Release runs the reset vector.

Source files
------------

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: takes over the 6502 bus at instruction boundaries to run the
// RESET / NMI / IRQ / BRK entry sequence: three stack pushes (PCH, PCL, P), vector
// fetch (low, high), then a PC load with the I flag set.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clk_enable          state advances only on enabled edges
//   irq, nmi            level IRQ, rising-edge NMI
//   i_flag              interrupt-disable flag
//   brk_req, boundary   decoder has BRK / decoder is at opcode fetch
//   pc_in, sp_in        current PC and SP
//   status_in           {N,V,B,D,I,Z,C}
//   data_in             memory read data
//   seq_active          sequencer owns address/rw/data_out
//   address, rw         bus address, 1=read 0=write
//   data_out            write data
//   sp_dec              decrement SP on this enabled cycle
//   pc_load, pc_value   load PC from the fetched vector
//   set_i               set I flag (with pc_load)
module interrupt_sequencer #(
  parameter logic [15:0] VEC_NMI = 16'hFFFA,
  parameter logic [15:0] VEC_RES = 16'hFFFC,
  parameter logic [15:0] VEC_IRQ = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_enable,
  input  logic        irq,
  input  logic        nmi,
  input  logic        i_flag,
  input  logic        brk_req,
  input  logic        boundary,
  input  logic [15:0] pc_in,
  input  logic [7:0]  sp_in,
  input  logic [6:0]  status_in,
  input  logic [7:0]  data_in,
  output logic        seq_active,
  output logic [15:0] address,
  output logic        rw,
  output logic [7:0]  data_out,
  output logic        sp_dec,
  output logic        pc_load,
  output logic [15:0] pc_value,
  output logic        set_i
);

  typedef enum logic [2:0] {
    StRstHold, StIdle, StPushPch, StPushPcl, StPushP, StVecLo, StVecHi, StLoadPc
  } state_e;

  typedef enum logic [1:0] {KindReset, KindNmi, KindIrq, KindBrk} kind_e;

  state_e      state_q, state_d;
  kind_e       kind_q, kind_d;
  logic        nmi_q;
  logic        nmi_pending_q, nmi_pending_d;
  logic [15:0] vec_q, vec_d;
  logic [7:0]  vec_lo_q, vec_hi_q;
  logic        nmi_rise;
  logic [7:0]  p_byte;

  assign nmi_rise = nmi & ~nmi_q;

  // Pushed P: bit 5 always 1, B replaced by "this is a BRK".
  assign p_byte = {status_in[6:5], 1'b1, (kind_q == KindBrk), status_in[3:0]};

  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    vec_d         = vec_q;
    nmi_pending_d = nmi_pending_q;
    unique case (state_q)
      StRstHold: state_d = StPushPch;
      StIdle: begin
        if (boundary) begin
          if (nmi_pending_q) begin
            kind_d  = KindNmi;
            state_d = StPushPch;
          end else if (brk_req) begin
            kind_d  = KindBrk;
            state_d = StPushPch;
          end else if (irq && !i_flag) begin
            kind_d  = KindIrq;
            state_d = StPushPch;
          end
        end
      end
      StPushPch: state_d = StPushPcl;
      StPushPcl: state_d = StPushP;
      StPushP: begin
        state_d = StVecLo;
        unique case (kind_q)
          KindReset: vec_d = VEC_RES;
          KindNmi: begin
            vec_d         = VEC_NMI;
            nmi_pending_d = 1'b0;
          end
          KindIrq, KindBrk: begin
            // A pending NMI hijacks the vector; the pushed P is left as-is.
            if (nmi_pending_q) begin
              vec_d         = VEC_NMI;
              nmi_pending_d = 1'b0;
            end else begin
              vec_d = VEC_IRQ;
            end
          end
        endcase
      end
      StVecLo:  state_d = StVecHi;
      StVecHi:  state_d = StLoadPc;
      StLoadPc: state_d = StIdle;
    endcase
    // A fresh edge on the clearing cycle must survive, so it is applied last.
    if (nmi_rise) nmi_pending_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StRstHold;
      kind_q        <= KindReset;
      nmi_q         <= 1'b0;
      nmi_pending_q <= 1'b0;
      vec_q         <= 16'h0000;
      vec_lo_q      <= 8'h00;
      vec_hi_q      <= 8'h00;
    end else if (clk_enable) begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      nmi_q         <= nmi;
      nmi_pending_q <= nmi_pending_d;
      vec_q         <= vec_d;
      if (state_q == StVecLo) vec_lo_q <= data_in;
      if (state_q == StVecHi) vec_hi_q <= data_in;
    end
  end

  always_comb begin
    seq_active = 1'b1;
    address    = 16'h0000;
    rw         = 1'b1;
    data_out   = 8'h00;
    sp_dec     = 1'b0;
    pc_load    = 1'b0;
    set_i      = 1'b0;
    pc_value   = {vec_hi_q, vec_lo_q};
    unique case (state_q)
      StRstHold: ;
      StIdle:    seq_active = 1'b0;
      StPushPch, StPushPcl, StPushP: begin
        address = {8'h01, sp_in};
        sp_dec  = 1'b1;
        // Reset entry performs dummy reads but still walks SP down.
        rw      = (kind_q == KindReset);
        unique case (state_q)
          StPushPch: data_out = pc_in[15:8];
          StPushPcl: data_out = pc_in[7:0];
          default:   data_out = p_byte;
        endcase
      end
      StVecLo: address = vec_q;
      StVecHi: address = vec_q + 16'd1;
      StLoadPc: begin
        pc_load = 1'b1;
        set_i   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, clk_enable, irq, nmi, i_flag, brk_req, boundary;
  logic [15:0] pc_in;
  logic [7:0]  sp_in;
  logic [6:0]  status_in;
  logic [7:0]  data_in;
  logic        seq_active, rw, sp_dec, pc_load, set_i;
  logic [15:0] address, pc_value;
  logic [7:0]  data_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  interrupt_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_enable (clk_enable),
    .irq        (irq),
    .nmi        (nmi),
    .i_flag     (i_flag),
    .brk_req    (brk_req),
    .boundary   (boundary),
    .pc_in      (pc_in),
    .sp_in      (sp_in),
    .status_in  (status_in),
    .data_in    (data_in),
    .seq_active (seq_active),
    .address    (address),
    .rw         (rw),
    .data_out   (data_out),
    .sp_dec     (sp_dec),
    .pc_load    (pc_load),
    .pc_value   (pc_value),
    .set_i      (set_i)
  );

  // Vector ROM seen by the sequencer.
  always_comb begin
    unique case (address)
      16'hFFFA: data_in = 8'hBC;
      16'hFFFB: data_in = 8'h9A;
      16'hFFFC: data_in = 8'h34;
      16'hFFFD: data_in = 8'h12;
      16'hFFFE: data_in = 8'h78;
      16'hFFFF: data_in = 8'h56;
      default:  data_in = 8'h00;
    endcase
  end

  typedef struct {
    logic b, irq, iflag, brk, nmi;
    logic [7:0] sp;
    logic sa, rw, ac;
    logic [15:0] addr;
    logic dc;
    logic [7:0] dout;
    logic spd, pcl;
    logic [15:0] pcv;
  } vec_t;

  vec_t tbl[31];

  function automatic vec_t mk(input logic b, irqv, ifl, brk, nm, input logic [7:0] sp,
                              input logic sa, rwe, ac, input logic [15:0] ad,
                              input logic dc, input logic [7:0] dout,
                              input logic spd, pcl, input logic [15:0] pcv);
    vec_t r;
    r.b = b; r.irq = irqv; r.iflag = ifl; r.brk = brk; r.nmi = nm; r.sp = sp;
    r.sa = sa; r.rw = rwe; r.ac = ac; r.addr = ad; r.dc = dc; r.dout = dout;
    r.spd = spd; r.pcl = pcl; r.pcv = pcv;
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic sa, rwe, ac, input logic [15:0] ad,
                           input logic dc, input logic [7:0] dout, input logic spd, pcl,
                           input logic [15:0] pcv);
    chk({tag, ".seq_active"}, 16'(seq_active), 16'(sa));
    chk({tag, ".rw"}, 16'(rw), 16'(rwe));
    chk({tag, ".sp_dec"}, 16'(sp_dec), 16'(spd));
    chk({tag, ".pc_load"}, 16'(pc_load), 16'(pcl));
    chk({tag, ".set_i"}, 16'(set_i), 16'(pcl));
    if (ac) chk({tag, ".address"}, address, ad);
    if (dc) chk({tag, ".data_out"}, 16'(data_out), 16'(dout));
    if (pcl) chk({tag, ".pc_value"}, pc_value, pcv);
  endtask

  task automatic look(input string tag, input logic [7:0] sp, input logic sa, rwe, ac,
                      input logic [15:0] ad, input logic dc, input logic [7:0] dout,
                      input logic spd, pcl, input logic [15:0] pcv);
    sp_in = sp;
    #1;
    check_out(tag, sa, rwe, ac, ad, dc, dout, spd, pcl, pcv);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset-entry sequence from RST_HOLD through IDLE.
  task automatic reset_run(input string tag);
    look({tag, ".hold"}, 8'hFF, 1, 1, 1, 16'h0000, 1, 8'h00, 0, 0, 16'h0);
    step();
    look({tag, ".pch"}, 8'hFF, 1, 1, 1, 16'h01FF, 0, 8'h00, 1, 0, 16'h0);
    step();
    look({tag, ".pcl"}, 8'hFE, 1, 1, 1, 16'h01FE, 0, 8'h00, 1, 0, 16'h0);
    step();
    look({tag, ".p"}, 8'hFD, 1, 1, 1, 16'h01FD, 0, 8'h00, 1, 0, 16'h0);
    step();
    look({tag, ".veclo"}, 8'hFC, 1, 1, 1, 16'hFFFC, 0, 8'h00, 0, 0, 16'h0);
    step();
    look({tag, ".vechi"}, 8'hFC, 1, 1, 1, 16'hFFFD, 0, 8'h00, 0, 0, 16'h0);
    step();
    look({tag, ".load"}, 8'hFC, 1, 1, 0, 16'h0, 0, 8'h00, 0, 1, 16'h1234);
    step();
    look({tag, ".idle"}, 8'hFC, 0, 1, 0, 16'h0, 0, 8'h00, 0, 0, 16'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; clk_enable = 1; irq = 0; nmi = 0; i_flag = 0; brk_req = 0; boundary = 0;
    pc_in = 16'hC005; sp_in = 8'hFF; status_in = 7'h40;

    // Reset held low: bus parked, no pulses.
    repeat (3) begin
      step();
      look("rst_low", 8'hFF, 1, 1, 1, 16'h0000, 1, 8'h00, 0, 0, 16'h0);
    end
    rst_n = 1;
    reset_run("reset");

    // IRQ, BRK with NMI hijack, follow-up IRQ, NMI priority over BRK/IRQ.
    tbl[0]  = mk(1,1,0,0,0, 8'hFF, 0,1,0,16'h0000, 0,8'h00, 0,0,16'h0);
    tbl[1]  = mk(0,0,0,0,0, 8'hFF, 1,0,1,16'h01FF, 1,8'hC0, 1,0,16'h0);
    tbl[2]  = mk(0,0,0,0,0, 8'hFE, 1,0,1,16'h01FE, 1,8'h05, 1,0,16'h0);
    tbl[3]  = mk(0,0,0,0,0, 8'hFD, 1,0,1,16'h01FD, 1,8'hA0, 1,0,16'h0);
    tbl[4]  = mk(0,0,0,0,0, 8'hFC, 1,1,1,16'hFFFE, 0,8'h00, 0,0,16'h0);
    tbl[5]  = mk(0,0,0,0,0, 8'hFC, 1,1,1,16'hFFFF, 0,8'h00, 0,0,16'h0);
    tbl[6]  = mk(0,0,0,0,0, 8'hFC, 1,1,0,16'h0000, 0,8'h00, 0,1,16'h5678);
    tbl[7]  = mk(1,0,0,1,0, 8'hFC, 0,1,0,16'h0000, 0,8'h00, 0,0,16'h0);
    tbl[8]  = mk(0,0,0,0,0, 8'hFC, 1,0,1,16'h01FC, 1,8'hC0, 1,0,16'h0);
    tbl[9]  = mk(0,0,0,0,1, 8'hFB, 1,0,1,16'h01FB, 1,8'h05, 1,0,16'h0);
    tbl[10] = mk(0,0,0,0,1, 8'hFA, 1,0,1,16'h01FA, 1,8'hB0, 1,0,16'h0);
    tbl[11] = mk(0,0,0,0,1, 8'hF9, 1,1,1,16'hFFFA, 0,8'h00, 0,0,16'h0);
    tbl[12] = mk(0,0,0,0,1, 8'hF9, 1,1,1,16'hFFFB, 0,8'h00, 0,0,16'h0);
    tbl[13] = mk(0,0,0,0,1, 8'hF9, 1,1,0,16'h0000, 0,8'h00, 0,1,16'h9ABC);
    tbl[14] = mk(1,1,0,0,1, 8'hF9, 0,1,0,16'h0000, 0,8'h00, 0,0,16'h0);
    tbl[15] = mk(0,0,0,0,1, 8'hF9, 1,0,1,16'h01F9, 1,8'hC0, 1,0,16'h0);
    tbl[16] = mk(0,0,0,0,1, 8'hF8, 1,0,1,16'h01F8, 1,8'h05, 1,0,16'h0);
    tbl[17] = mk(0,0,0,0,1, 8'hF7, 1,0,1,16'h01F7, 1,8'hA0, 1,0,16'h0);
    tbl[18] = mk(0,0,0,0,1, 8'hF6, 1,1,1,16'hFFFE, 0,8'h00, 0,0,16'h0);
    tbl[19] = mk(0,0,0,0,1, 8'hF6, 1,1,1,16'hFFFF, 0,8'h00, 0,0,16'h0);
    tbl[20] = mk(0,0,0,0,1, 8'hF6, 1,1,0,16'h0000, 0,8'h00, 0,1,16'h5678);
    tbl[21] = mk(0,0,0,0,0, 8'hF6, 0,1,0,16'h0000, 0,8'h00, 0,0,16'h0);
    tbl[22] = mk(0,0,0,0,1, 8'hF6, 0,1,0,16'h0000, 0,8'h00, 0,0,16'h0);
    tbl[23] = mk(1,1,0,1,1, 8'hF6, 0,1,0,16'h0000, 0,8'h00, 0,0,16'h0);
    tbl[24] = mk(0,0,0,0,1, 8'hF6, 1,0,1,16'h01F6, 1,8'hC0, 1,0,16'h0);
    tbl[25] = mk(0,0,0,0,1, 8'hF5, 1,0,1,16'h01F5, 1,8'h05, 1,0,16'h0);
    tbl[26] = mk(0,0,0,0,1, 8'hF4, 1,0,1,16'h01F4, 1,8'hA0, 1,0,16'h0);
    tbl[27] = mk(0,0,0,0,1, 8'hF3, 1,1,1,16'hFFFA, 0,8'h00, 0,0,16'h0);
    tbl[28] = mk(0,0,0,0,1, 8'hF3, 1,1,1,16'hFFFB, 0,8'h00, 0,0,16'h0);
    tbl[29] = mk(0,0,0,0,1, 8'hF3, 1,1,0,16'h0000, 0,8'h00, 0,1,16'h9ABC);
    tbl[30] = mk(0,0,0,0,1, 8'hF3, 0,1,0,16'h0000, 0,8'h00, 0,0,16'h0);

    for (int i = 0; i < 31; i++) begin
      boundary = tbl[i].b; irq = tbl[i].irq; i_flag = tbl[i].iflag;
      brk_req = tbl[i].brk; nmi = tbl[i].nmi;
      look($sformatf("tbl%0d", i), tbl[i].sp, tbl[i].sa, tbl[i].rw, tbl[i].ac, tbl[i].addr,
           tbl[i].dc, tbl[i].dout, tbl[i].spd, tbl[i].pcl, tbl[i].pcv);
      step();
    end
    boundary = 0; irq = 0; brk_req = 0; nmi = 0;

    // Masked IRQ: never taken.
    i_flag = 1; irq = 1; boundary = 1;
    repeat (20) begin
      look("masked", 8'hF0, 0, 1, 0, 16'h0, 0, 8'h00, 0, 0, 16'h0);
      step();
    end
    i_flag = 0; irq = 0; boundary = 0;

    // Stall inside VEC_LO.
    irq = 1; boundary = 1;
    look("stall.idle", 8'hF0, 0, 1, 0, 16'h0, 0, 8'h00, 0, 0, 16'h0);
    step();
    irq = 0; boundary = 0;
    look("stall.pch", 8'hF0, 1, 0, 1, 16'h01F0, 1, 8'hC0, 1, 0, 16'h0);
    step();
    look("stall.pcl", 8'hEF, 1, 0, 1, 16'h01EF, 1, 8'h05, 1, 0, 16'h0);
    step();
    look("stall.p", 8'hEE, 1, 0, 1, 16'h01EE, 1, 8'hA0, 1, 0, 16'h0);
    step();
    look("stall.veclo", 8'hED, 1, 1, 1, 16'hFFFE, 0, 8'h00, 0, 0, 16'h0);
    clk_enable = 0;
    repeat (4) begin
      step();
      look("stall.frozen", 8'hED, 1, 1, 1, 16'hFFFE, 0, 8'h00, 0, 0, 16'h0);
    end
    clk_enable = 1;
    step();
    look("stall.vechi", 8'hED, 1, 1, 1, 16'hFFFF, 0, 8'h00, 0, 0, 16'h0);
    step();
    look("stall.load", 8'hED, 1, 1, 0, 16'h0, 0, 8'h00, 0, 1, 16'h5678);
    step();
    look("stall.idle2", 8'hED, 0, 1, 0, 16'h0, 0, 8'h00, 0, 0, 16'h0);

    // Abort an NMI sequence with reset during PUSH_P.
    nmi = 1; boundary = 1;
    step();
    look("abort.pend", 8'hED, 0, 1, 0, 16'h0, 0, 8'h00, 0, 0, 16'h0);
    step();
    boundary = 0;
    look("abort.pch", 8'hED, 1, 0, 1, 16'h01ED, 1, 8'hC0, 1, 0, 16'h0);
    step();
    look("abort.pcl", 8'hEC, 1, 0, 1, 16'h01EC, 1, 8'h05, 1, 0, 16'h0);
    step();
    look("abort.p", 8'hEB, 1, 0, 1, 16'h01EB, 1, 8'hA0, 1, 0, 16'h0);
    rst_n = 0; nmi = 0;
    look("abort.rst", 8'hEB, 1, 1, 1, 16'h0000, 1, 8'h00, 0, 0, 16'h0);
    step();
    rst_n = 1;
    reset_run("abort.reset");
    boundary = 1;
    repeat (3) begin
      step();
      look("abort.nopend", 8'hFC, 0, 1, 0, 16'h0, 0, 8'h00, 0, 0, 16'h0);
    end
    boundary = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
